// File: rtl/vme_csr_func_decoder.sv
// VME64x CR/CSR function block: staged/active ADER registers, module enable,
// and the address decoder that maps (VME address, AM) onto a function hit.

module vme_func_match #(
  parameter int g_win_log2 = 19
) (
  input  logic [31:0] ader,
  input  logic [31:0] addr,
  input  logic [5:0]  am,
  output logic        hit
);
  logic a24, a32;
  logic unused_ok;

  // Bits below the window and the ADER's reserved bit never take part in the match.
  assign unused_ok = &{1'b0, ader[1], ader[g_win_log2-1:8], addr[g_win_log2-1:0]};

  always_comb begin
    a24 = (am[5:3] == 3'b111);
    a32 = (am[5:3] == 3'b001);
    hit = 1'b0;
    if (!ader[0] && am == ader[7:2]) begin
      if (a24)      hit = (addr[23:g_win_log2] == ader[23:g_win_log2]);
      else if (a32) hit = (addr[31:g_win_log2] == ader[31:g_win_log2]);
    end
  end
endmodule

module vme_csr_func_decoder #(
  parameter int g_num_func = 2,
  parameter int g_win_log2 = 19
) (
  input  logic                    clk_sys_i,
  input  logic                    rst_i,
  input  logic                    csr_stb_i,
  input  logic                    csr_we_i,
  input  logic [18:0]             csr_addr_i,
  input  logic [7:0]              csr_data_i,
  output logic [7:0]              csr_data_o,
  output logic                    csr_ack_o,
  input  logic                    dec_req_i,
  input  logic [31:0]             dec_addr_i,
  input  logic [5:0]              dec_am_i,
  output logic                    dec_ack_o,
  output logic                    dec_hit_o,
  output logic [2:0]              dec_func_o,
  output logic                    module_enable_o,
  output logic [32*g_num_func-1:0] ader_o
);
  localparam logic [18:0] ADER_BASE = 19'h7ff63;
  localparam logic [18:0] COMMIT    = 19'h7ff33;
  localparam logic [18:0] BIT_SET   = 19'h7fffb;
  localparam logic [18:0] BIT_CLR   = 19'h7fff7;

  typedef enum logic [1:0] {S_IDLE, S_RESULT, S_WAIT_LOW} dec_state_t;

  typedef struct packed {
    logic       ack;
    logic       hit;
    logic [2:0] func;
  } dec_rsp_t;

  logic [g_num_func-1:0][31:0] staged, active;
  logic                        enable;
  logic                        csr_armed;
  logic [7:0]                  rd_data;

  logic [g_num_func-1:0]       match;
  logic                        any_hit;
  logic [2:0]                  win;
  dec_state_t                  state, state_nx;
  logic                        load, clear;
  dec_rsp_t                    dec_q;

  assign module_enable_o = enable;
  assign ader_o          = active;
  assign dec_ack_o       = dec_q.ack;
  assign dec_hit_o       = dec_q.hit;
  assign dec_func_o      = dec_q.func;

  always_comb begin
    rd_data = 8'h00;
    for (int f = 0; f < g_num_func; f++)
      for (int k = 0; k < 4; k++)
        if (csr_addr_i == ADER_BASE + 19'(16*f + 4*k)) rd_data = staged[f][31-8*k -: 8];
    if (csr_addr_i == BIT_SET || csr_addr_i == BIT_CLR) rd_data = {3'b000, enable, 4'b0000};
  end

  // One ack per strobe: the strobe must be seen low before another access is taken.
  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      csr_armed  <= 1'b1;
      csr_ack_o  <= 1'b0;
      csr_data_o <= 8'h00;
      staged     <= '0;
      active     <= '0;
      enable     <= 1'b0;
    end else begin
      csr_ack_o  <= 1'b0;
      csr_data_o <= 8'h00;
      if (!csr_stb_i) csr_armed <= 1'b1;
      if (csr_stb_i && csr_armed) begin
        csr_armed  <= 1'b0;
        csr_ack_o  <= 1'b1;
        csr_data_o <= csr_we_i ? 8'h00 : rd_data;
        if (csr_we_i) begin
          for (int f = 0; f < g_num_func; f++)
            for (int k = 0; k < 4; k++)
              if (csr_addr_i == ADER_BASE + 19'(16*f + 4*k))
                staged[f][31-8*k -: 8] <= csr_data_i;
          if (csr_addr_i == COMMIT  && csr_data_i[0]) active <= staged;
          if (csr_addr_i == BIT_SET && csr_data_i[4]) enable <= 1'b1;
          if (csr_addr_i == BIT_CLR && csr_data_i[4]) enable <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < g_num_func; g++) begin : g_func
    vme_func_match #(.g_win_log2(g_win_log2)) u_match (
      .ader (active[g]),
      .addr (dec_addr_i),
      .am   (dec_am_i),
      .hit  (match[g])
    );
  end

  // Lowest matching index wins.
  always_comb begin
    any_hit = 1'b0;
    win     = 3'd0;
    for (int f = g_num_func - 1; f >= 0; f--)
      if (match[f] && enable) begin
        any_hit = 1'b1;
        win     = 3'(f);
      end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    clear    = 1'b0;
    case (state)
      S_IDLE:     if (dec_req_i) begin state_nx = S_RESULT; load = 1'b1; end
      S_RESULT:   if (!dec_req_i) begin state_nx = S_WAIT_LOW; clear = 1'b1; end
      // Turnaround so a req that bounces straight back is not taken as a fresh request.
      S_WAIT_LOW: state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      dec_q <= '0;
    end else begin
      state <= state_nx;
      if (load)       dec_q <= '{ack: 1'b1, hit: any_hit, func: win};
      else if (clear) dec_q <= '0;
    end
  end
endmodule
